card_ctrl: RTL and testbench
============================

# card_ctrl

Control stage for the card-payment terminal, sitting directly upstream of the seven-segment display stage. It takes the operator switches and buttons, runs the terminal state machine (off / hello / consume / result), keeps the card balance, and drives the `state`, `cost`, `left`, `cancel_flag` and `press` signals that the display consumes. All amounts are unsigned half-yuan units: bit 0 is the 0.5 digit, bits [7:1] are whole yuan.

## Interface
Parameters:
- `DEB_CYC`, 20: stable cycles a raw button must hold before it is accepted.
- `RESULT_CYC`, 3000: cycles the RESULT state is held before returning to HELLO.
- `TIMEOUT_CYC`, 10000: inactivity limit in CONSUME (used only with the timeout option).

Ports:
- `clk_N`  in  1  system/scan clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `power`  in  1  raw power switch, level.
- `card_in`  in  1  raw card-present switch, level.
- `bal_init`  in  8  balance on the inserted card, half units.
- `key_half`  in  1  raw button: add 0.5.
- `key_one`  in  1  raw button: add 1.0.
- `key_clr`  in  1  raw button: clear cost.
- `key_ok`  in  1  raw button: confirm.
- `key_cancel`  in  1  raw button: cancel.
- `state`  out  2  00 OFF, 01 HELLO, 10 CONSUME, 11 RESULT.
- `cost`  out  8  current or charged cost, half units.
- `left`  out  8  remaining balance, half units.
- `cancel_flag`  out  1  high throughout RESULT entered by cancel.
- `press`  out  1  high throughout RESULT entered by confirm.

## Operation
- Every raw input goes through a 2-flop synchronizer and a `DEB_CYC` debounce. Buttons yield a one-cycle rising-edge pulse. `card_in` yields both a debounced level and a rising-edge pulse.
- Internal `balance` register, 8 bits. `MAX_HALF` = 199 (99.5, the display's two-digit limit).
- OFF: all outputs 0. Debounced `power`=1 -> HELLO.
- Debounced `power`=0 in any state -> OFF next cycle, clearing `cost`, `left`, `balance`, flags and timers. This has priority over everything else.
- HELLO: `cost`=`left`=0. A `card_in` rising pulse -> CONSUME, with `balance` <= min(`bal_init`, 199), `cost` <= 0, `left` <= `balance`.
- CONSUME, priority from highest to lowest:
  - card level low -> HELLO, `cost`/`left` 0, `balance` untouched.
  - cancel pulse -> RESULT, `cancel_flag`=1, `cost`/`left` held, so `cost`+`left` = balance.
  - ok pulse -> RESULT, `press`=1, `balance` <= `balance`-`cost`, `left` = new balance, `cost` held.
  - clr pulse -> `cost` 0, `left` = `balance`.
  - half/one pulse -> `cost` += 1 or 2 only if the sum is <= `balance`; otherwise ignored, no partial add. If both arrive in the same cycle, only `key_one` is applied.
- Invariant in CONSUME: `left` = `balance` - `cost`, and it never goes negative. Arithmetic is 9-bit internally, compared before commit.
- RESULT: all outputs frozen and key pulses ignored for `RESULT_CYC` cycles. Then -> HELLO with flags cleared and `cost`/`left` 0. Re-entering CONSUME requires a new card rising edge, so a card left in place does not retrigger.
- `cancel_flag` and `press` are mutually exclusive and are never high outside RESULT.

## Timing
- Reset: `state`=00, `cost`=0, `left`=0, `cancel_flag`=0, `press`=0, synchronizers and timers cleared. The block stays in OFF until `power` is debounced high.
- Raw edge to internal pulse: 2 + `DEB_CYC` cycles. Pulse to registered output change: 1 cycle.
- All outputs are registered and change only on posedge `clk_N`. `state`, `cost`, `left` and the flags for a transition update in the same cycle.
- The RESULT timer counts from the cycle after entry. Exit happens on count `RESULT_CYC`-1.
- Reset asserted mid-transaction: immediate return to reset values. No charge is committed.

## Configuration
- `CARD_TIMEOUT_EN` defined: a 16-bit inactivity counter runs in CONSUME and clears on any key pulse. When it reaches `TIMEOUT_CYC`, the block acts exactly as a cancel pulse (RESULT, `cancel_flag`=1).
- `CARD_TIMEOUT_EN` undefined: no counter, and CONSUME waits indefinitely.

## Structure
- Shared package `card_pkg`:
  - state encodings `ST_OFF`, `ST_HELLO`, `ST_CONSUME`, `ST_RESULT`;
  - `MAX_HALF`=8'd199;
  - increments `INC_HALF`=1, `INC_ONE`=2.
- Sub-module `key_pulse`: synchronizer, `DEB_CYC` debounce, and rising-edge pulse plus level output. It is instantiated once per raw input (7 instances).

## Test plan
- Reset, then `power`=1 -> HELLO after debounce; with `card_in` at 0, `cost`=`left`=0.
- Insert card with `bal_init`=100; press one ×3 and half ×1 -> CONSUME, `cost`=7, `left`=93. Press ok -> RESULT, `press`=1, `left`=93, `cost`=7. After `RESULT_CYC` cycles -> HELLO, outputs 0.
- `bal_init`=5; press one ×3 -> `cost`=4 (third add rejected), `left`=1. Press cancel -> RESULT, `cancel_flag`=1, `cost`+`left`=5, `balance` unchanged.
- `bal_init`=240 -> `left`=199. Pulse ok and cancel in the same cycle -> cancel wins, `press`=0.
- Remove the card in CONSUME with `cost`=10 -> HELLO, no charge. Drop `power` during RESULT -> OFF next cycle, all outputs 0.
- With `CARD_TIMEOUT_EN` and `TIMEOUT_CYC`=50: insert a card and idle 50 cycles -> RESULT with `cancel_flag`=1. Without the macro, still CONSUME after 20000 cycles.

Source files
------------

// File: rtl/card_pkg.sv
// Shared definitions for the card-payment terminal control stage.
// Contents: terminal state encoding (matches the 2-bit `state` bus read by the
// display stage), display amount limit and key increments, all in half-yuan units.
package card_pkg;

    typedef enum logic [1:0] {
        ST_OFF     = 2'b00,
        ST_HELLO   = 2'b01,
        ST_CONSUME = 2'b10,
        ST_RESULT  = 2'b11
    } state_e;

    // Largest amount the two-digit display can show (99.5).
    localparam logic [7:0] MAX_HALF = 8'd199;

    localparam logic [7:0] INC_HALF = 8'd1;
    localparam logic [7:0] INC_ONE  = 8'd2;

endpackage

// File: rtl/key_pulse.sv
// Conditioning for one raw switch or button.
// A 2-flop synchronizer feeds a debouncer that accepts a new level only after
// it has differed from the accepted level for DEB_CYC consecutive cycles.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   raw        : raw asynchronous input
//   level      : debounced level
//   pulse      : one-cycle pulse on a debounced rising edge (aligned with level)
module key_pulse #(
    parameter int unsigned DEB_CYC = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int unsigned CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic          s1_q, s2_q;
    logic          lvl_q, lvl_d;
    logic          pls_q, pls_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        lvl_d = lvl_q;
        cnt_d = '0;
        // Any cycle of agreement restarts the stability count.
        if (s2_q != lvl_q) begin
            if (cnt_q == CW'(DEB_CYC - 1)) begin
                lvl_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        pls_d = lvl_d & ~lvl_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            lvl_q <= 1'b0;
            pls_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= raw;
            s2_q  <= s1_q;
            lvl_q <= lvl_d;
            pls_q <= pls_d;
            cnt_q <= cnt_d;
        end
    end

    assign level = lvl_q;
    assign pulse = pls_q;

endmodule

// File: rtl/card_ctrl.sv
// Control stage of the card-payment terminal (feeds the seven-segment stage).
// Runs the OFF/HELLO/CONSUME/RESULT machine and keeps the card balance.
// Optional feature: define CARD_TIMEOUT_EN to cancel a CONSUME session after
// TIMEOUT_CYC cycles without any key pulse.
// Ports:
//   clk_N, rst_n          : clock, asynchronous active-low reset
//   power, card_in        : raw level switches
//   bal_init[7:0]         : balance on the inserted card (half units)
//   key_half/one/clr/ok/cancel : raw buttons
//   state[1:0]            : 00 OFF, 01 HELLO, 10 CONSUME, 11 RESULT
//   cost[7:0], left[7:0]  : cost and remaining balance (half units)
//   cancel_flag, press    : RESULT entered by cancel / by confirm
module card_ctrl
    import card_pkg::*;
#(
    parameter int unsigned DEB_CYC     = 20,
    parameter int unsigned RESULT_CYC  = 3000,
    parameter int unsigned TIMEOUT_CYC = 10000
) (
    input  logic       clk_N,
    input  logic       rst_n,
    input  logic       power,
    input  logic       card_in,
    input  logic [7:0] bal_init,
    input  logic       key_half,
    input  logic       key_one,
    input  logic       key_clr,
    input  logic       key_ok,
    input  logic       key_cancel,
    output logic [1:0] state,
    output logic [7:0] cost,
    output logic [7:0] left,
    output logic       cancel_flag,
    output logic       press
);

    localparam int unsigned RW = (RESULT_CYC > 1) ? $clog2(RESULT_CYC) : 1;

    localparam int unsigned K_POWER  = 0;
    localparam int unsigned K_CARD   = 1;
    localparam int unsigned K_HALF   = 2;
    localparam int unsigned K_ONE    = 3;
    localparam int unsigned K_CLR    = 4;
    localparam int unsigned K_OK     = 5;
    localparam int unsigned K_CANCEL = 6;

    logic [6:0] raw_v, lvl_v, pls_v;

    assign raw_v = {key_cancel, key_ok, key_clr, key_one, key_half, card_in, power};

    for (genvar gi = 0; gi < 7; gi++) begin : g_key
        key_pulse #(.DEB_CYC(DEB_CYC)) u_key (
            .clk   (clk_N),
            .rst_n (rst_n),
            .raw   (raw_v[gi]),
            .level (lvl_v[gi]),
            .pulse (pls_v[gi])
        );
    end

    logic unused_sigs;
    assign unused_sigs = ^{lvl_v[6:2], pls_v[K_POWER]};

    state_e        state_q, state_d;
    logic [7:0]    cost_q, cost_d;
    logic [7:0]    left_q, left_d;
    logic [7:0]    bal_q, bal_d;
    logic          cancel_q, cancel_d;
    logic          press_q, press_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [8:0]    sum_9;
    logic          timeout;

`ifdef CARD_TIMEOUT_EN
    logic [15:0] tcnt_q, tcnt_d;
    logic        key_any;

    assign key_any = |pls_v[6:2];

    always_comb begin
        tcnt_d = '0;
        if (state_q == ST_CONSUME && !key_any) begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    assign timeout = (state_q == ST_CONSUME) && (tcnt_q == 16'(TIMEOUT_CYC));

    always_ff @(posedge clk_N or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end
`else
    logic [15:0] unused_tmo;
    assign unused_tmo = 16'(TIMEOUT_CYC);
    assign timeout    = 1'b0;
`endif

    // key_one takes precedence when both add buttons pulse together.
    assign sum_9 = {1'b0, cost_q} + (pls_v[K_ONE] ? {1'b0, INC_ONE} : {1'b0, INC_HALF});

    always_comb begin
        state_d  = state_q;
        cost_d   = cost_q;
        left_d   = left_q;
        bal_d    = bal_q;
        cancel_d = cancel_q;
        press_d  = press_q;
        rcnt_d   = rcnt_q;

        unique case (state_q)
            ST_OFF: begin
                if (lvl_v[K_POWER]) state_d = ST_HELLO;
            end
            ST_HELLO: begin
                cost_d = '0;
                left_d = '0;
                if (pls_v[K_CARD]) begin
                    state_d = ST_CONSUME;
                    bal_d   = (bal_init > MAX_HALF) ? MAX_HALF : bal_init;
                    left_d  = (bal_init > MAX_HALF) ? MAX_HALF : bal_init;
                end
            end
            ST_CONSUME: begin
                if (!lvl_v[K_CARD]) begin
                    state_d = ST_HELLO;
                    cost_d  = '0;
                    left_d  = '0;
                end else if (pls_v[K_CANCEL] || timeout) begin
                    state_d  = ST_RESULT;
                    cancel_d = 1'b1;
                    rcnt_d   = '0;
                end else if (pls_v[K_OK]) begin
                    state_d = ST_RESULT;
                    press_d = 1'b1;
                    bal_d   = bal_q - cost_q;
                    left_d  = bal_q - cost_q;
                    rcnt_d  = '0;
                end else if (pls_v[K_CLR]) begin
                    cost_d = '0;
                    left_d = bal_q;
                end else if (pls_v[K_HALF] || pls_v[K_ONE]) begin
                    if (sum_9 <= {1'b0, bal_q}) begin
                        cost_d = sum_9[7:0];
                        left_d = bal_q - sum_9[7:0];
                    end
                end
            end
            ST_RESULT: begin
                if (rcnt_q == RW'(RESULT_CYC - 1)) begin
                    state_d  = ST_HELLO;
                    cost_d   = '0;
                    left_d   = '0;
                    cancel_d = 1'b0;
                    press_d  = 1'b0;
                    rcnt_d   = '0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            default: state_d = ST_OFF;
        endcase

        if (!lvl_v[K_POWER]) begin
            state_d  = ST_OFF;
            cost_d   = '0;
            left_d   = '0;
            bal_d    = '0;
            cancel_d = 1'b0;
            press_d  = 1'b0;
            rcnt_d   = '0;
        end
    end

    always_ff @(posedge clk_N or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_OFF;
            cost_q   <= '0;
            left_q   <= '0;
            bal_q    <= '0;
            cancel_q <= 1'b0;
            press_q  <= 1'b0;
            rcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            cost_q   <= cost_d;
            left_q   <= left_d;
            bal_q    <= bal_d;
            cancel_q <= cancel_d;
            press_q  <= press_d;
            rcnt_q   <= rcnt_d;
        end
    end

    assign state       = state_q;
    assign cost        = cost_q;
    assign left        = left_q;
    assign cancel_flag = cancel_q;
    assign press       = press_q;

endmodule

// File: tb/tb_card_ctrl.sv
// Directed plus randomized bench for card_ctrl against a transaction-level
// model of the terminal (one model update per debounced key press).
module tb_card_ctrl;

    localparam int DEB = 4;
    localparam int RES = 100;
    localparam int TMO = 50;

    // key mask bits for press_keys
    localparam logic [4:0] K_HALF   = 5'b00001;
    localparam logic [4:0] K_ONE    = 5'b00010;
    localparam logic [4:0] K_CLR    = 5'b00100;
    localparam logic [4:0] K_OK     = 5'b01000;
    localparam logic [4:0] K_CANCEL = 5'b10000;

    logic       clk_N = 1'b0;
    logic       rst_n = 1'b0;
    logic       power = 1'b0;
    logic       card_in = 1'b0;
    logic [7:0] bal_init = 8'd0;
    logic       key_half = 1'b0, key_one = 1'b0, key_clr = 1'b0, key_ok = 1'b0, key_cancel = 1'b0;
    logic [1:0] state;
    logic [7:0] cost, left;
    logic       cancel_flag, press;

    always #5 clk_N = ~clk_N;

    card_ctrl #(.DEB_CYC(DEB), .RESULT_CYC(RES), .TIMEOUT_CYC(TMO)) dut (
        .clk_N       (clk_N),
        .rst_n       (rst_n),
        .power       (power),
        .card_in     (card_in),
        .bal_init    (bal_init),
        .key_half    (key_half),
        .key_one     (key_one),
        .key_clr     (key_clr),
        .key_ok      (key_ok),
        .key_cancel  (key_cancel),
        .state       (state),
        .cost        (cost),
        .left        (left),
        .cancel_flag (cancel_flag),
        .press       (press)
    );

    int checks = 0;
    int errors = 0;

    // model: 0 OFF, 1 HELLO, 2 CONSUME, 3 RESULT
    int m_state = 0, m_bal = 0, m_cost = 0, m_left = 0, m_cancel = 0, m_press = 0;

    // length of the most recent RESULT stay, in cycles
    int run_len = 0, last_run = 0;
    always @(negedge clk_N) begin
        if (state == 2'b11) begin
            run_len <= run_len + 1;
        end else begin
            if (run_len != 0) last_run <= run_len;
            run_len <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, 32'(state), m_state);
        chk({tag, ".cost"}, 32'(cost), m_cost);
        chk({tag, ".left"}, 32'(left), m_left);
        chk({tag, ".cancel"}, 32'(cancel_flag), m_cancel);
        chk({tag, ".press"}, 32'(press), m_press);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_N);
    endtask

    task automatic settle();
        cyc(DEB + 8);
    endtask

    task automatic model_clear();
        m_cost = 0; m_left = 0; m_cancel = 0; m_press = 0;
    endtask

    task automatic model_key(input logic [4:0] k);
        int inc;
        if (m_state != 2) return;
        if (k[4]) begin
            m_state = 3; m_cancel = 1;
        end else if (k[3]) begin
            m_state = 3; m_press = 1;
            m_bal = m_bal - m_cost;
            m_left = m_bal;
        end else if (k[2]) begin
            m_cost = 0; m_left = m_bal;
        end else if (k[0] || k[1]) begin
            inc = k[1] ? 2 : 1;
            if (m_cost + inc <= m_bal) begin
                m_cost = m_cost + inc;
                m_left = m_bal - m_cost;
            end
        end
    endtask

    task automatic press_keys(input logic [4:0] k, input string tag);
        {key_cancel, key_ok, key_clr, key_one, key_half} = k;
        settle();
        {key_cancel, key_ok, key_clr, key_one, key_half} = 5'b0;
        settle();
        model_key(k);
        check_all(tag);
    endtask

    task automatic insert(input int b, input string tag);
        bal_init = 8'(b);
        card_in = 1'b1;
        settle();
        if (m_state == 1) begin
            m_state = 2;
            m_bal = (b > 199) ? 199 : b;
            m_cost = 0;
            m_left = m_bal;
        end
        check_all(tag);
    endtask

    task automatic remove(input string tag);
        card_in = 1'b0;
        settle();
        if (m_state == 2) begin
            m_state = 1; m_cost = 0; m_left = 0;
        end
        check_all(tag);
    endtask

    task automatic wait_exit(input string tag);
        int n = 0;
        while (state == 2'b11 && n < RES + 50) begin
            cyc(1);
            n++;
        end
        cyc(1);
        chk({tag, ".left_result"}, 32'(state != 2'b11), 1);
        chk({tag, ".result_len"}, 32'(last_run), RES);
        m_state = 1;
        model_clear();
        check_all(tag);
    endtask

    initial begin
        logic [4:0] k;
        int n;

        // reset and OFF
        cyc(3);
        check_all("reset");
        rst_n = 1'b1;
        cyc(2 * DEB + 10);
        check_all("off_idle");

        power = 1'b1;
        settle();
        m_state = 1;
        check_all("hello");

        // bal 100: one x3, half -> cost 7 left 93, then ok
        insert(100, "ins100");
        press_keys(K_ONE, "a.one1");
        press_keys(K_ONE, "a.one2");
        press_keys(K_ONE, "a.one3");
        press_keys(K_HALF, "a.half");
        chk("a.cost7", 32'(cost), 7);
        chk("a.left93", 32'(left), 93);
        press_keys(K_OK, "a.ok");
        chk("a.press", 32'(press), 1);
        press_keys(K_ONE, "a.frozen");
        wait_exit("a.exit");
        remove("a.remove");

        // bal 5: third add rejected, then cancel
        insert(5, "ins5");
        press_keys(K_ONE, "b.one1");
        press_keys(K_ONE, "b.one2");
        press_keys(K_ONE, "b.one3");
        chk("b.cost4", 32'(cost), 4);
        chk("b.left1", 32'(left), 1);
        press_keys(K_CANCEL, "b.cancel");
        chk("b.sum5", 32'(cost) + 32'(left), 5);
        wait_exit("b.exit");
        remove("b.remove");

        // bal 240 clamps to 199; ok+cancel together -> cancel
        insert(240, "ins240");
        chk("c.left199", 32'(left), 199);
        press_keys(K_OK | K_CANCEL, "c.okcancel");
        chk("c.nopress", 32'(press), 0);
        wait_exit("c.exit");
        remove("c.remove");

        // card pulled with cost 10 -> HELLO, nothing charged
        insert(50, "ins50");
        for (int i = 0; i < 5; i++) press_keys(K_ONE, "d.one");
        chk("d.cost10", 32'(cost), 10);
        remove("d.pull");

        // power drop during RESULT
        insert(30, "ins30");
        press_keys(K_HALF, "e.half");
        press_keys(K_OK, "e.ok");
        power = 1'b0;
        settle();
        m_state = 0; m_bal = 0;
        model_clear();
        check_all("e.power_off");
        card_in = 1'b0;
        power = 1'b1;
        settle();
        settle();
        m_state = 1;
        check_all("e.power_on");

        // asynchronous reset mid-session
        insert(80, "ins80");
        press_keys(K_ONE, "f.one1");
        press_keys(K_ONE, "f.one2");
        #2 rst_n = 1'b0;
        #1;
        m_state = 0; m_bal = 0;
        model_clear();
        check_all("f.async_rst");
        cyc(2);
        rst_n = 1'b1;
        card_in = 1'b0;
        settle();
        settle();
        m_state = 1;
        check_all("f.after_rst");

        // randomized sessions
        for (int it = 0; it < 6; it++) begin
            insert($urandom_range(0, 255), "r.ins");
            n = $urandom_range(3, 8);
            for (int j = 0; j < n; j++) begin
                case ($urandom_range(0, 4))
                    0: k = K_HALF;
                    1, 2: k = K_ONE;
                    3: k = K_CLR;
                    default: k = K_HALF | K_ONE;
                endcase
                press_keys(k, "r.key");
                chk("r.inv", 32'(cost) + 32'(left), m_bal);
            end
            press_keys(($urandom_range(0, 1) == 1) ? K_OK : K_CANCEL, "r.end");
            wait_exit("r.exit");
            remove("r.remove");
        end

        // inactivity behaviour
        insert(60, "ins60");
`ifdef CARD_TIMEOUT_EN
        n = 0;
        while (state != 2'b11 && n < TMO + 40) begin
            cyc(1);
            n++;
        end
        m_state = 3; m_cancel = 1;
        check_all("g.timeout");
        wait_exit("g.exit");
`else
        cyc(20000);
        check_all("g.no_timeout");
`endif
        remove("g.remove");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
